shape_report_ctrl: RTL
======================

// Module: shape_report_ctrl
// PURPOSE
//  Sequences per-frame shape/colour codes from the image processor to the Arduino.
//  Samples the processor's 3-bit RESULT once per frame, at the VSYNC rising edge.
//  Debounces: a code is reported only after STABLE_FRAMES consecutive identical frames.
//  Delivers each new code over a 4-phase REQ/ACK handshake, with timeout and error flag.
// PARAMETERS
//  STABLE_FRAMES   3           consecutive identical frames required; range 1..15
//  TIMEOUT_CYCLES  25_000_000  CLK cycles allowed in any ACK wait state (1 s at 25 MHz)
//  REPORT_NULL     1           1: code 3'b111 (no colour) is reportable; 0: never reported
// PORTS
//  CLK            in   1   system clock (the VGA/processor clock)
//  RESET          in   1   asynchronous, active-high reset
//  VGA_VSYNC_NEG  in   1   same VSYNC signal that the image processor sees
//  RESULT_IN      in   3   processor RESULT; valid from the edge after a VSYNC rise
//  ARD_ACK        in   1   Arduino acknowledge; asynchronous, 2-flop synchronised inside
//  ARD_DATA       out  3   code being reported; stable while ARD_REQ=1
//  ARD_REQ        out  1   request to Arduino
//  STABLE_RESULT  out  3   last debounced code (updates even if not reported)
//  FRAME_COUNT    out  8   frames sampled since reset, wraps 255->0
//  TIMEOUT_ERR    out  1   sticky; set on any handshake timeout; cleared only by RESET
// BEHAVIOUR
//  Reset (async, all regs)
//   - ARD_REQ=0, ARD_DATA=3'b111, STABLE_RESULT=3'b111, FRAME_COUNT=0, TIMEOUT_ERR=0
//   - internal: cand=3'b111, cnt=0, last_rep=3'b111, pend=0, state=IDLE, tmo=0
//   - RESET asserted mid-handshake drops ARD_REQ at once (asynchronously)
//  Frame sampling (vs_d = VGA_VSYNC_NEG registered once)
//   - E0: edge where VGA_VSYNC_NEG=1 && vs_d=0; sets samp_pend
//   - E1: RESULT_IN sampled; samp_pend cleared; FRAME_COUNT+1
//  Debounce at E1
//   - RESULT_IN==cand: cnt = min(cnt+1, STABLE_FRAMES)
//   - otherwise: cand<=RESULT_IN, cnt<=1
//   - new cnt==STABLE_FRAMES: STABLE_RESULT<=cand
//   - if also cand!=last_rep and (cand!=3'b111 or REPORT_NULL): pend<=1, pend_val<=cand
//   - pend is one-deep, latest wins: a newer qualifying code overwrites pend_val
//   - if cand returns to last_rep before the send starts, pend is cleared
//   - debounce keeps running in every FSM state
//  FSM (ack_s = synchronised ARD_ACK)
//   - IDLE: pend && !ack_s -> LOAD. While ack_s=1, stay in IDLE (stray ACK never starts a send).
//   - LOAD: ARD_DATA<=pend_val, pend<=0 -> REQ (data leads REQ by 1 cycle).
//   - REQ: ARD_REQ=1. On ack_s=1: last_rep<=ARD_DATA -> REL.
//     On tmo==TIMEOUT_CYCLES-1: ARD_REQ<=0, TIMEOUT_ERR<=1, last_rep unchanged -> IDLE.
//   - REL: ARD_REQ=0. On ack_s=0 -> IDLE.
//     On timeout: TIMEOUT_ERR<=1 -> IDLE (code counts as delivered).
//   - tmo clears on every state change and counts only in REQ and REL.
//   - ARD_DATA holds its last value in IDLE.
//  Latency
//   - ARD_REQ rises at E3 when pend was set at E1 and FSM was IDLE with ack_s=0
//   - ACK to FSM: 2 synchroniser cycles + 1 cycle
//  Simultaneous events
//   - VSYNC edge during any handshake state: sampled normally
//   - pend set in the same cycle LOAD clears it: the set wins (new value stays pending)
// STRUCTURE
//  - shape_codes.vh (shared include): RESULT encodings.
//    RED_DIAMOND=001, RED_TRI=010, RED_SQ=011, BLUE_DIAMOND=100, BLUE_TRI=101,
//    BLUE_SQ=110, NONE=111.
//  - shape_codes.vh also holds the FSM state localparams: IDLE, LOAD, REQ, REL.
//  - One sub-module: sync_2ff (parameterised width, async reset to 0), used for ARD_ACK.
//  - Debounce, sampler and FSM are inline in this module.
// TESTING
//  1) Reset
//     - Stimulus: RESET pulse mid-frame.
//     - Response: all outputs at reset values; no ARD_REQ for frames of 3'b111.
//  2) Report after debounce (STABLE_FRAMES=3)
//     - Stimulus: frames 011,011,011; Arduino acks 4 cycles after REQ.
//     - Response: STABLE_RESULT=011 after frame 3; ARD_DATA=011; REQ at E3 of frame 3;
//       one handshake only, including for a 4th frame of 011.
//  3) Debounce break
//     - Stimulus: frames 101,101,110,101,101.
//     - Response: no REQ; cnt restarts at 110; STABLE_RESULT stays 111.
//  4) Latest wins
//     - Stimulus: hold ACK low during handshake 1; during it, make 100 then 110 stable.
//     - Response: after REL->IDLE, a single handshake with ARD_DATA=110.
//  5) Timeout (TIMEOUT_CYCLES=16)
//     - Stimulus: never ack.
//     - Response: REQ falls after 16 cycles; TIMEOUT_ERR=1 until RESET;
//       the same code is re-sent on its next stable frame.
//  6) Stray ACK and REPORT_NULL=0
//     - Stimulus (a): ARD_ACK high while pend=1.
//     - Response (a): REQ held off until ACK low.
//     - Stimulus (b): after 011 is delivered, three frames of 111.
//     - Response (b): no REQ.

Source files
------------

// File: rtl/shape_report_ctrl_pkg.sv
// Shared definitions for the shape/colour report controller: result codes,
// handshake FSM states and the reportability rule.
package shape_report_ctrl_pkg;

  localparam logic [2:0] CODE_RED_DIAMOND  = 3'b001;
  localparam logic [2:0] CODE_RED_TRI      = 3'b010;
  localparam logic [2:0] CODE_RED_SQ       = 3'b011;
  localparam logic [2:0] CODE_BLUE_DIAMOND = 3'b100;
  localparam logic [2:0] CODE_BLUE_TRI     = 3'b101;
  localparam logic [2:0] CODE_BLUE_SQ      = 3'b110;
  localparam logic [2:0] CODE_NONE         = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    REQ  = 2'd2,
    REL  = 2'd3
  } state_e;

  // "No colour" is only sent to the Arduino when the build asks for it.
  function automatic logic is_reportable(input logic [2:0] code, input logic report_null);
    is_reportable = (code != CODE_NONE) || report_null;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; both stages reset to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] meta_r;

  // Metastability filter: D -> meta_r -> Q.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      meta_r <= {WIDTH{1'b0}};
      Q      <= {WIDTH{1'b0}};
    end else begin
      meta_r <= D;
      Q      <= meta_r;
    end
  end

endmodule

// File: rtl/shape_report_ctrl.sv
// Samples the image processor's RESULT once per frame, debounces it and reports
// each newly stable code to the Arduino over a 4-phase REQ/ACK handshake.
module shape_report_ctrl
  import shape_report_ctrl_pkg::*;
#(
  parameter int STABLE_FRAMES  = 3,
  parameter int TIMEOUT_CYCLES = 25_000_000,
  parameter bit REPORT_NULL    = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       VGA_VSYNC_NEG,
  input  logic [2:0] RESULT_IN,
  input  logic       ARD_ACK,
  output logic [2:0] ARD_DATA,
  output logic       ARD_REQ,
  output logic [2:0] STABLE_RESULT,
  output logic [7:0] FRAME_COUNT,
  output logic       TIMEOUT_ERR
);

  localparam int               TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]       STABLE_MAX = 4'(STABLE_FRAMES);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE    = TMO_W'(1'b1);
  localparam logic [TMO_W-1:0] TMO_ZERO   = TMO_W'(1'b0);

  logic             vs_d_r;
  logic             samp_pend_r;
  logic [2:0]       cand_r;
  logic [3:0]       cnt_r;
  logic [2:0]       last_rep_r;
  logic             pend_r;
  logic [2:0]       pend_val_r;
  state_e           state_r;
  logic [TMO_W-1:0] tmo_r;

  logic             ack_sync_s;
  logic             e0_s;
  logic             load_start_s;
  logic [2:0]       cand_nxt_s;
  logic [3:0]       cnt_nxt_s;
  logic             stable_hit_s;
  logic             qualify_s;

  sync_2ff #(.WIDTH(1)) u_ack_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .D     (ARD_ACK),
    .Q     (ack_sync_s)
  );

  assign e0_s         = VGA_VSYNC_NEG & ~vs_d_r;
  assign load_start_s = (state_r == IDLE) && pend_r && !ack_sync_s;

  // Candidate/count update that a sample of RESULT_IN would produce.
  always_comb begin
    cand_nxt_s   = cand_r;
    cnt_nxt_s    = cnt_r;
    stable_hit_s = 1'b0;
    qualify_s    = 1'b0;
    if (RESULT_IN == cand_r) begin
      cand_nxt_s = cand_r;
      cnt_nxt_s  = (cnt_r >= STABLE_MAX) ? STABLE_MAX : cnt_r + 4'd1;
    end else begin
      cand_nxt_s = RESULT_IN;
      cnt_nxt_s  = 4'd1;
    end
    stable_hit_s = (cnt_nxt_s == STABLE_MAX);
    qualify_s    = stable_hit_s && (cand_nxt_s != last_rep_r) &&
                   is_reportable(cand_nxt_s, REPORT_NULL);
  end

  // Frame sampler and debouncer; owns the one-deep pending report slot.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vs_d_r        <= 1'b0;
      samp_pend_r   <= 1'b0;
      cand_r        <= CODE_NONE;
      cnt_r         <= 4'd0;
      STABLE_RESULT <= CODE_NONE;
      FRAME_COUNT   <= 8'd0;
      pend_r        <= 1'b0;
      pend_val_r    <= CODE_NONE;
    end else begin
      vs_d_r      <= VGA_VSYNC_NEG;
      samp_pend_r <= e0_s;
      if (load_start_s) begin
        pend_r <= 1'b0;
      end
      // Placed after the load clear so a same-cycle new report stays pending.
      if (samp_pend_r) begin
        FRAME_COUNT <= FRAME_COUNT + 8'd1;
        cand_r      <= cand_nxt_s;
        cnt_r       <= cnt_nxt_s;
        if (stable_hit_s) begin
          STABLE_RESULT <= cand_nxt_s;
        end
        if (qualify_s) begin
          pend_r     <= 1'b1;
          pend_val_r <= cand_nxt_s;
        end else if (cand_nxt_s == last_rep_r) begin
          pend_r <= 1'b0;
        end
      end
    end
  end

  // Handshake FSM; data is launched on entry to LOAD so it leads REQ by a cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= IDLE;
      ARD_REQ     <= 1'b0;
      ARD_DATA    <= CODE_NONE;
      last_rep_r  <= CODE_NONE;
      tmo_r       <= TMO_ZERO;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          tmo_r <= TMO_ZERO;
          if (load_start_s) begin
            ARD_DATA <= pend_val_r;
            state_r  <= LOAD;
          end
        end
        LOAD: begin
          ARD_REQ <= 1'b1;
          tmo_r   <= TMO_ZERO;
          state_r <= REQ;
        end
        REQ: begin
          if (ack_sync_s) begin
            last_rep_r <= ARD_DATA;
            ARD_REQ    <= 1'b0;
            tmo_r      <= TMO_ZERO;
            state_r    <= REL;
          end else if (tmo_r == TMO_LAST) begin
            ARD_REQ     <= 1'b0;
            TIMEOUT_ERR <= 1'b1;
            tmo_r       <= TMO_ZERO;
            state_r     <= IDLE;
          end else begin
            tmo_r <= tmo_r + TMO_ONE;
          end
        end
        REL: begin
          if (!ack_sync_s) begin
            tmo_r   <= TMO_ZERO;
            state_r <= IDLE;
          end else if (tmo_r == TMO_LAST) begin
            TIMEOUT_ERR <= 1'b1;
            tmo_r       <= TMO_ZERO;
            state_r     <= IDLE;
          end else begin
            tmo_r <= tmo_r + TMO_ONE;
          end
        end
        default: begin
          ARD_REQ <= 1'b0;
          tmo_r   <= TMO_ZERO;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
